// File: rtl/array_dim_walker.sv
// Odometer-style sequencer over an NDIMS-deep array, dim 1 outermost. It emits one
// index tuple per accepted valid/ready beat, together with a linear count and a last flag.
module array_dim_walker #(
    parameter int unsigned NDIMS = 4,
    parameter int unsigned IDXW  = 32,
    parameter int unsigned CNTW  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NDIMS*IDXW-1:0] cfg_left,
    input  logic [NDIMS*IDXW-1:0] cfg_right,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NDIMS*IDXW-1:0] out_idx,
    output logic [CNTW-1:0]       out_lin,
    output logic                  out_last,
    output logic                  done,
    output logic [CNTW-1:0]       total
);

    localparam int unsigned SZW = IDXW + 1;

    typedef enum logic {IDLE, RUN} state_t;
    typedef logic signed [IDXW-1:0] idx_t;

    state_t          state_q, state_d;
    idx_t            left_q  [NDIMS];
    idx_t            left_d  [NDIMS];
    idx_t            right_q [NDIMS];
    idx_t            right_d [NDIMS];
    idx_t            idx_q   [NDIMS];
    idx_t            idx_d   [NDIMS];
    logic [CNTW-1:0] lin_q, lin_d;
    logic [CNTW-1:0] total_q, total_d, total_c;
    logic            busy_q, busy_d;
    logic            valid_q, valid_d;
    logic            last_q, last_d;
    logic            done_q, done_d;
    logic            carry;
    idx_t            l_c, r_c;
    logic [SZW-1:0]  diff_c, mag_c;

    // Element count of the incoming configuration: product of |left-right|+1, truncated
    always_comb begin
        total_c = CNTW'(1);
        l_c     = '0;
        r_c     = '0;
        diff_c  = '0;
        mag_c   = '0;
        for (int unsigned d = 0; d < NDIMS; d++) begin
            l_c     = $signed(cfg_left[d*IDXW +: IDXW]);
            r_c     = $signed(cfg_right[d*IDXW +: IDXW]);
            diff_c  = {l_c[IDXW-1], l_c} - {r_c[IDXW-1], r_c};
            mag_c   = diff_c[SZW-1] ? SZW'(-diff_c) : diff_c;
            total_c = total_c * CNTW'(mag_c + SZW'(1));
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        left_d  = left_q;
        right_d = right_q;
        idx_d   = idx_q;
        lin_d   = lin_q;
        total_d = total_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        carry   = 1'b1;
        last_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    for (int unsigned d = 0; d < NDIMS; d++) begin
                        left_d[d]  = $signed(cfg_left[d*IDXW +: IDXW]);
                        right_d[d] = $signed(cfg_right[d*IDXW +: IDXW]);
                        idx_d[d]   = $signed(cfg_left[d*IDXW +: IDXW]);
                    end
                    lin_d   = '0;
                    total_d = total_c;
                    busy_d  = 1'b1;
                    valid_d = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort || (out_ready && last_q)) begin
                    busy_d  = 1'b0;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (out_ready) begin
                    lin_d = lin_q + CNTW'(1);
                    // Fastest dim not at its right steps; every faster dim reloads its left
                    for (int d = int'(NDIMS) - 1; d >= 0; d--) begin
                        if (carry) begin
                            if (idx_q[d] == right_q[d]) begin
                                idx_d[d] = left_q[d];
                            end else begin
                                carry = 1'b0;
                                if (left_q[d] >= right_q[d]) begin
                                    idx_d[d] = idx_q[d] - idx_t'(1);
                                end else begin
                                    idx_d[d] = idx_q[d] + idx_t'(1);
                                end
                            end
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Last flag follows the tuple that will be presented next cycle
        last_d = valid_d;
        for (int unsigned d = 0; d < NDIMS; d++) begin
            if (idx_d[d] != right_d[d]) begin
                last_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            for (int unsigned d = 0; d < NDIMS; d++) begin
                left_q[d]  <= '0;
                right_q[d] <= '0;
                idx_q[d]   <= '0;
            end
            lin_q   <= '0;
            total_q <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            left_q  <= left_d;
            right_q <= right_d;
            idx_q   <= idx_d;
            lin_q   <= lin_d;
            total_q <= total_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        out_idx = '0;
        for (int unsigned d = 0; d < NDIMS; d++) begin
            out_idx[d*IDXW +: IDXW] = idx_q[d];
        end
    end

    assign busy      = busy_q;
    assign out_valid = valid_q;
    assign out_lin   = lin_q;
    assign out_last  = last_q;
    assign done      = done_q;
    assign total     = total_q;

endmodule

// File: tb/tb_array_dim_walker.sv
// Directed bench for array_dim_walker: full walks with and without backpressure, degenerate
// and negative bounds, abort, and mid-walk reset, all checked against a mixed-radix model.
module tb_array_dim_walker;

    localparam int unsigned NDIMS = 4;
    localparam int unsigned IDXW  = 32;
    localparam int unsigned CNTW  = 32;
    localparam int unsigned VW    = NDIMS * IDXW;

    logic            clk = 1'b0;
    logic            rst;
    logic [VW-1:0]   cfg_left, cfg_right;
    logic            start, abort, out_ready;
    logic            busy, out_valid, out_last, done;
    logic [VW-1:0]   out_idx;
    logic [CNTW-1:0] out_lin, total;

    int vectors     = 0;
    int miscompares = 0;
    int bl [NDIMS];
    int br [NDIMS];

    always #5 clk = ~clk;

    array_dim_walker #(.NDIMS(NDIMS), .IDXW(IDXW), .CNTW(CNTW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_left  (cfg_left),
        .cfg_right (cfg_right),
        .start     (start),
        .abort     (abort),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_lin   (out_lin),
        .out_last  (out_last),
        .done      (done),
        .total     (total)
    );

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [VW-1:0] pk(input int a, input int b, input int c, input int d);
        logic [VW-1:0] v;
        v = '0;
        v[0*IDXW +: IDXW] = IDXW'(a);
        v[1*IDXW +: IDXW] = IDXW'(b);
        v[2*IDXW +: IDXW] = IDXW'(c);
        v[3*IDXW +: IDXW] = IDXW'(d);
        return v;
    endfunction

    // Beat n decomposed as a mixed-radix number, dim NDIMS least significant
    function automatic logic [VW-1:0] model(input int n);
        logic [VW-1:0] v;
        int rem, sz, off;
        v   = '0;
        rem = n;
        for (int d = int'(NDIMS) - 1; d >= 0; d--) begin
            sz  = (bl[d] >= br[d]) ? bl[d] - br[d] + 1 : br[d] - bl[d] + 1;
            off = rem % sz;
            rem = rem / sz;
            v[d*IDXW +: IDXW] = IDXW'((bl[d] >= br[d]) ? bl[d] - off : bl[d] + off);
        end
        return v;
    endfunction

    function automatic int tot();
        int p;
        p = 1;
        for (int d = 0; d < int'(NDIMS); d++) begin
            p = p * ((bl[d] >= br[d]) ? bl[d] - br[d] + 1 : br[d] - bl[d] + 1);
        end
        return p;
    endfunction

    task automatic set_bounds(input int l1, input int r1, input int l2, input int r2,
                              input int l3, input int r3, input int l4, input int r4);
        bl[0] = l1; br[0] = r1;
        bl[1] = l2; br[1] = r2;
        bl[2] = l3; br[2] = r3;
        bl[3] = l4; br[3] = r4;
        for (int d = 0; d < int'(NDIMS); d++) begin
            cfg_left[d*IDXW +: IDXW]  = IDXW'(bl[d]);
            cfg_right[d*IDXW +: IDXW] = IDXW'(br[d]);
        end
    endtask

    // One walk; returns in the cycle after the walk ends (done cycle, or reset cycle)
    task automatic walk(input bit rnd, input int abort_at, input int rst_at,
                        input int start_at, input bit hand);
        int n, cyc, t;
        bit fin, xfer;
        t = tot();
        start = 1'b1;
        abort = 1'b0;
        tick();
        start = 1'b0;
        chk("busy_on", busy, 1);
        chk("valid_on", out_valid, 1);
        chk("total", total, t);
        n   = 0;
        cyc = 0;
        fin = 1'b0;
        while (!fin && cyc < 4000) begin
            cyc++;
            chk("idx", out_idx, model(n));
            chk("lin", out_lin, n);
            chk("last", out_last, n == t - 1);
            if (hand) begin
                if (n == 0)   chk("hand_b0", out_idx, pk(1, 2, 3, 2));
                if (n == 1)   chk("hand_b1", out_idx, pk(1, 2, 3, 1));
                if (n == 2)   chk("hand_b2", out_idx, pk(1, 2, 2, 2));
                if (n == 279) chk("hand_b279", out_idx, pk(5, 8, 0, 1));
            end
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start     = (n == start_at);
            if (n == rst_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                chk("rst_busy", busy, 0);
                chk("rst_valid", out_valid, 0);
                chk("rst_idx", out_idx, 0);
                chk("rst_lin", out_lin, 0);
                chk("rst_last", out_last, 0);
                chk("rst_done", done, 0);
                chk("rst_total", total, 0);
                fin = 1'b1;
            end else if (n == abort_at) begin
                abort     = 1'b1;
                out_ready = 1'b1;
                tick();
                abort = 1'b0;
                chk("abort_valid", out_valid, 0);
                chk("abort_busy", busy, 0);
                chk("abort_done", done, 1);
                chk("abort_lin", out_lin, n);
                fin = 1'b1;
            end else begin
                xfer = out_ready;
                tick();
                start = 1'b0;
                if (xfer) begin
                    if (n == t - 1) begin
                        chk("end_valid", out_valid, 0);
                        chk("end_busy", busy, 0);
                        chk("end_done", done, 1);
                        fin = 1'b1;
                    end
                    n++;
                end
            end
        end
        start     = 1'b0;
        out_ready = 1'b0;
        if (!fin) chk("timeout", 0, 1);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b0;
        cfg_left  = '0;
        cfg_right = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_busy", busy, 0);
        chk("reset_valid", out_valid, 0);
        chk("reset_idx", out_idx, 0);
        chk("reset_lin", out_lin, 0);
        chk("reset_last", out_last, 0);
        chk("reset_done", done, 0);
        chk("reset_total", total, 0);

        // abort while idle has no effect
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("idle_abort_busy", busy, 0);
        chk("idle_abort_done", done, 0);

        // [1:5][2:8][3:0][2:1] free-flowing, then back-to-back with random stalls
        set_bounds(1, 5, 2, 8, 3, 0, 2, 1);
        walk(1'b0, -1, -1, -1, 1'b1);
        walk(1'b1, -1, -1, -1, 1'b1);
        tick();
        chk("post_done", done, 0);
        chk("post_busy", busy, 0);
        chk("post_valid", out_valid, 0);

        // all dims [0:0]: one beat
        set_bounds(0, 0, 0, 0, 0, 0, 0, 0);
        walk(1'b0, -1, -1, -1, 1'b0);
        tick();

        // dim 4 [-2:1], others [7:7]
        set_bounds(7, 7, 7, 7, 7, 7, -2, 1);
        chk("neg_total_model", 32'(tot()), 4);
        walk(1'b1, -1, -1, -1, 1'b0);
        tick();

        // abort at beat 10, start pulsed at beat 5
        set_bounds(1, 5, 2, 8, 3, 0, 2, 1);
        walk(1'b0, 10, -1, 5, 1'b0);
        tick();
        chk("abort_done_clr", done, 0);

        // reset at beat 50, then a fresh full walk
        walk(1'b1, -1, 50, -1, 1'b0);
        tick();
        chk("rst_no_done", done, 0);
        walk(1'b0, -1, -1, -1, 1'b1);
        tick();
        chk("final_done_clr", done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
